// File: rtl/mult_div_seq.sv
// Iterative signed MULT/DIV sequencer for the HI/LO unit. It runs a shift-add multiply or a
// restoring divide over WIDTH steps, then applies the sign correction and writes HI/LO.
module mult_div_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic               sign_p_q, sign_p_d;
    logic               sign_r_q, sign_r_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quot_neg, rem_neg;

    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    // MULT: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    // DIV: acc low half holds the dividend, with quotient bits shifting in from the right.
    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opb_q};

    assign prod_neg = -acc_q;
    assign quot_neg = -acc_q[WIDTH-1:0];
    assign rem_neg  = -rem_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        sign_p_d   = sign_p_q;
        sign_r_d   = sign_r_q;
        opb_d      = opb_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    if (op && (b == '0)) begin
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d  = StRun;
                        cnt_d    = '0;
                        op_d     = op;
                        sign_p_d = a[WIDTH-1] ^ b[WIDTH-1];
                        sign_r_d = a[WIDTH-1];
                        opb_d    = op ? abs_b : abs_a;
                        acc_d    = {{WIDTH{1'b0}}, (op ? abs_a : abs_b)};
                        rem_d    = '0;
                    end
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (op_q) begin
                        if (!div_trial[WIDTH]) begin
                            rem_d = div_trial[WIDTH-1:0];
                        end else begin
                            rem_d = div_shift[WIDTH-1:0];
                        end
                        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_trial[WIDTH]};
                    end else begin
                        acc_d = mul_next;
                    end
                    if (cnt_q == LastCnt) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (!abort) begin
                    if (op_q) begin
                        lo_d = sign_p_q ? quot_neg : acc_q[WIDTH-1:0];
                        hi_d = sign_r_q ? rem_neg : rem_q;
                    end else begin
                        {hi_d, lo_d} = sign_p_q ? prod_neg : acc_q;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= 1'b0;
            sign_p_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            opb_q      <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            sign_p_q   <= sign_p_d;
            sign_r_q   <= sign_r_d;
            opb_q      <= opb_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
